calc_display_mux: RTL and testbench
===================================

# calc_display_mux

Time-multiplexed driver for the calculator's eight 7-segment digits. Sits directly downstream of `calc_top`: consumes its `displays[7:0]` segment patterns and `status`, and drives one shared segment bus plus eight digit anodes on the board. It latches whole frames so digits never tear, and inserts guard time at each digit switch to suppress ghosting. When `calc_top` reports error, it blinks the display.

## Interface
- `REFRESH_DIV`, 1000: clock cycles per digit slot. Legal range ≥ 2.
- `GUARD`, 2: leading cycles of each slot with all anodes off. Legal range 0 ≤ GUARD < REFRESH_DIV.
- `BLINK_FRAMES`, 32: complete 8-digit frames per blink half-period. Legal range ≥ 1.

Ports:
- `clock`  in  1: single system clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `displays`  in  7 × [7:0]: unpacked array `[6:0] displays [7:0]`. Per-digit segment patterns, active-low (0 = segment lit). Index 0 is the rightmost digit.
- `status`  in  2: calc_top status; 2'b11 = error.
- `seg`  out  7: shared segment bus, active-low.
- `an`  out  8: digit anodes, active-low, at most one bit low.
- `digit_sel`  out  3: index of the digit currently in its slot (debug).

## Operation
- Internal state:
  - `ph`: phase counter, 0..REFRESH_DIV-1.
  - `dig`: digit index, 0..7.
  - `frame[7:0]`: seven-bit snapshot registers.
  - `err_q`: latched error flag.
  - `fcnt`: frame counter, 0..BLINK_FRAMES-1.
  - `blink`: one-bit blink phase.
- Slot sequencing:
  - `ph` increments every cycle.
  - At REFRESH_DIV-1, `ph` wraps to 0 and `dig` increments, wrapping 7→0.
  - Digits are scanned in order 0,1,…,7,0,…
- Frame snapshot:
  - On each cycle where the next slot is `dig`=0, `ph`=0, all eight `displays` entries are copied into `frame`.
  - `err_q` is set to (`status`==2'b11) on the same cycle.
  - Input changes mid-frame do not appear until the next frame.
- Blink:
  - At each frame start, `fcnt` increments.
  - When `fcnt` wraps from BLINK_FRAMES-1 to 0, `blink` toggles.
  - `blink` keeps running whether or not there is an error.
- Output rule, evaluated for the current slot (`dig`=d, `ph`=p) and registered:
  - If p < GUARD: `an`=8'hFF and `seg`=7'h7F.
  - Else: `an` = ~(8'b1 << d).
  - Else, if `err_q` and `blink`: `seg` = 7'h7F, while anodes keep scanning.
  - Otherwise: `seg` = `frame[d]`.
  - `digit_sel` = d in every slot, including guard cycles.

## Timing
- Reset values, asynchronous on `reset` low:
  - `an`=8'hFF, `seg`=7'h7F, `digit_sel`=0.
  - `ph`=0, `dig`=0, `fcnt`=0, `blink`=0, `err_q`=0.
  - `frame` all 7'h7F.
- Reset asserted mid-scan: outputs go to reset values immediately, not at the next clock edge.
- First rising edge after `reset` rises starts slot d=0, p=0 and performs the first frame snapshot.
  - Edge n (n ≥ 1) presents slot s = n-1: d = (s / REFRESH_DIV) mod 8, p = s mod REFRESH_DIV.
- Latency: a `displays` value present at a frame-start edge reaches `seg` at the first non-guard cycle of that digit's slot in the same frame.
  - This is GUARD + d·REFRESH_DIV edges after the snapshot.
- Frame period: 8·REFRESH_DIV cycles. Blink half-period: BLINK_FRAMES·8·REFRESH_DIV cycles.
- GUARD=0: no blanking; anodes switch directly from digit d to d+1 on one edge.
- Error cleared mid-frame: the display keeps blinking until the next frame-start edge resamples `status`.
- Invariant: `an` never has more than one zero bit, on any cycle.

## Test plan
All scenarios use REFRESH_DIV=4, GUARD=1, BLINK_FRAMES=2 (frame = 32 cycles).

1. **Reset:**
   - Hold `reset`=0 for 3 cycles, then release → `an`=FF and `seg`=7F during reset.
   - Edge 1 → `an`=FF (guard).
   - Edges 2–4 → `an`=FE.
   - Edge 6 → `an`=FD.
2. **Frame scan:**
   - Stimulus: `displays[i]` = 7'h40+i, `status`=0.
   - Over one frame, digit i's non-guard cycles show `an`=~(1<<i) and `seg`=7'h40+i.
   - Every edge 1+4k shows `an`=FF.
3. **Tear-free snapshot:**
   - Change `displays[5]` to 7'h12 at edge 10.
   - `seg` for digit 5 in the current frame stays at its old value.
   - Digit 5 shows 7'h12 at edge 55, i.e. 32+22+1.
4. **Error blink:**
   - Set `status`=2'b11 before a frame start.
   - `seg` shows data for frames while `blink`=0.
   - `seg`=7F for the next 64 cycles of non-guard slots, with anodes still scanning.
   - The pattern then alternates.
5. **Error clear:**
   - Drop `status` to 0 mid-frame while blanked.
   - Remains blank until the next frame-start edge, then shows data.
6. **Asynchronous reset mid-scan:**
   - Assert `reset` between edges during digit 3.
   - `an`=FF and `seg`=7F immediately, with no clock edge needed.
   - After release, the scan restarts at digit 0.

Source files
------------

// File: rtl/calc_display_mux_if.sv
// calc_display_mux_if: bundles the calculator-side inputs (segment patterns,
// status) and the board-side outputs (shared segment bus, anodes, debug index).
//   master : drives displays/status, observes seg/an/digit_sel
//   slave  : the display multiplexer itself
interface calc_display_mux_if;
    logic [6:0] displays [7:0];
    logic [1:0] status;
    logic [6:0] seg;
    logic [7:0] an;
    logic [2:0] digit_sel;

    modport master (
        output displays,
        output status,
        input  seg,
        input  an,
        input  digit_sel
    );

    modport slave (
        input  displays,
        input  status,
        output seg,
        output an,
        output digit_sel
    );
endinterface

// File: rtl/calc_display_mux.sv
// calc_display_mux: time-multiplexed driver for eight active-low 7-segment
// digits. Snapshots a whole frame of patterns at each frame start so digits
// never tear, blanks all anodes for GUARD cycles at each slot start, and
// blinks the segments when the calculator reports an error.
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous active-low reset
//   bus.slave  - displays[7:0] / status in; seg, an, digit_sel out (registered)
module calc_display_mux #(
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned GUARD        = 2,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic               clock,
    input  logic               reset,
    calc_display_mux_if.slave  bus
);

    localparam int unsigned PH_W   = (REFRESH_DIV  > 2) ? $clog2(REFRESH_DIV)  : 1;
    localparam int unsigned FC_W   = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIG_W  = 3;
    localparam int unsigned AN_W   = 8;

    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(REFRESH_DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(BLINK_FRAMES - 1);
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [AN_W-1:0]  AN_OFF    = 8'hFF;

    logic [PH_W-1:0]  ph_q,    ph_d;
    logic [DIG_W-1:0] dig_q,   dig_d;
    logic [FC_W-1:0]  fcnt_q,  fcnt_d;
    logic             blink_q, blink_d;
    logic             err_q,   err_d;
    logic [SEG_W-1:0] frame_q [7:0];
    logic [SEG_W-1:0] frame_d [7:0];

    logic [SEG_W-1:0] seg_q,       seg_d;
    logic [AN_W-1:0]  an_q,        an_d;
    logic [DIG_W-1:0] digit_sel_q, digit_sel_d;

    logic frame_start;
    logic in_guard;

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph_q        <= '0;
            dig_q       <= '0;
            fcnt_q      <= '0;
            blink_q     <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                frame_q[i] <= SEG_BLANK;
            end
            seg_q       <= SEG_BLANK;
            an_q        <= AN_OFF;
            digit_sel_q <= '0;
        end else begin
            ph_q        <= ph_d;
            dig_q       <= dig_d;
            fcnt_q      <= fcnt_d;
            blink_q     <= blink_d;
            err_q       <= err_d;
            for (int i = 0; i < 8; i++) begin
                frame_q[i] <= frame_d[i];
            end
            seg_q       <= seg_d;
            an_q        <= an_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    // Slot sequencing, frame snapshot and blink timebase.
    // (ph_q, dig_q) name the slot the next edge presents, so a frame start is
    // the edge where both are zero.
    always_comb begin
        ph_d    = ph_q + PH_W'(1);
        dig_d   = dig_q;
        fcnt_d  = fcnt_q;
        blink_d = blink_q;
        err_d   = err_q;
        for (int i = 0; i < 8; i++) begin
            frame_d[i] = frame_q[i];
        end

        frame_start = (ph_q == '0) && (dig_q == '0);

        if (ph_q == PH_LAST) begin
            ph_d  = '0;
            dig_d = dig_q + DIG_W'(1);
        end

        if (frame_start) begin
            for (int i = 0; i < 8; i++) begin
                frame_d[i] = bus.displays[i];
            end
            err_d = (bus.status == 2'b11);
            if (fcnt_q == FC_LAST) begin
                fcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                fcnt_d  = fcnt_q + FC_W'(1);
            end
        end
    end

    // Next output values; they use the freshly snapshotted frame so data
    // captured at a frame start can appear on that same edge when GUARD=0.
    always_comb begin
        an_d        = AN_OFF;
        seg_d       = SEG_BLANK;
        digit_sel_d = dig_q;

        in_guard = (32'(ph_q) < GUARD);

        if (!in_guard) begin
            an_d = ~(AN_W'(1) << dig_q);
            if (!(err_d && blink_d)) begin
                seg_d = frame_d[dig_q];
            end
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.digit_sel = digit_sel_q;

endmodule

// File: tb/tb_calc_display_mux.sv
// tb_calc_display_mux: randomized stimulus against a slot-arithmetic
// reference model of the display multiplexer.
module tb_calc_display_mux;

    localparam int unsigned RD = 4;
    localparam int unsigned G  = 1;
    localparam int unsigned BF = 2;
    localparam int unsigned FRAME = 8 * RD;

    logic clock;
    logic reset;

    calc_display_mux_if bus ();

    calc_display_mux #(
        .REFRESH_DIV  (RD),
        .GUARD        (G),
        .BLINK_FRAMES (BF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    int n       = 0;          // edges since reset release

    logic [6:0] snap [8];     // model's latched frame
    bit         err_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) snap[i] = 7'h7F;
        err_m = 1'b0;
        n     = 0;
    endtask

    // One clock: advance the model by slot arithmetic, then compare outputs.
    task automatic step();
        int s, d, p, k;
        bit blink;
        logic [7:0] an_e;
        logic [6:0] seg_e;
        @(posedge clock);
        n++;
        s = n - 1;
        d = (s / RD) % 8;
        p = s % RD;
        k = s / FRAME;
        if (d == 0 && p == 0) begin
            for (int i = 0; i < 8; i++) snap[i] = bus.displays[i];
            err_m = (bus.status == 2'b11);
        end
        // blink toggles after every BF frame-start increments, counting this frame's
        blink = (((k + 1) / BF) % 2) != 0;
        if (p < int'(G)) begin
            an_e  = 8'hFF;
            seg_e = 7'h7F;
        end else begin
            an_e  = ~(8'h01 << d);
            seg_e = (err_m && blink) ? 7'h7F : snap[d];
        end
        #1;
        check("an", 32'(bus.an), 32'(an_e));
        check("seg", 32'(bus.seg), 32'(seg_e));
        check("digit_sel", 32'(bus.digit_sel), 32'(d));
        check("an_single_low", 32'($countones(~bus.an) <= 1), 32'd1);
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    initial begin
        int guard_cnt;
        logic [6:0] v;

        reset      = 1'b0;
        bus.status = 2'b00;
        for (int i = 0; i < 8; i++) bus.displays[i] = 7'(8'h40 + i);
        model_reset();

        // Reset held for 3 cycles
        repeat (3) @(posedge clock);
        #1;
        check("rst_an", 32'(bus.an), 32'hFF);
        check("rst_seg", 32'(bus.seg), 32'h7F);
        check("rst_dsel", 32'(bus.digit_sel), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Frame scan, with a mid-frame change to digit 5 that must wait a frame
        run_to(10);
        bus.displays[5] = 7'h12;
        run_to(55);
        check("tear_free_d5", 32'(bus.seg), 32'h12);
        run_to(64);

        // Error asserted before frame 2 start; dropped mid-frame while blanked
        bus.status = 2'b11;
        run_to(180);
        check("err_blank", 32'(bus.seg), 32'h7F);
        bus.status = 2'b00;
        run_to(200);
        check("err_cleared", 32'(bus.seg), 32'(bus.displays[1]));
        run_to(224);

        // Randomized display contents and status
        repeat (6 * FRAME) begin
            if ($urandom_range(7) == 0) begin
                v = 7'($urandom);
                bus.displays[$urandom_range(7)] = v;
            end
            if ($urandom_range(31) == 0) bus.status = 2'($urandom);
            step();
        end
        bus.status = 2'b00;

        // Async reset between edges while digit 3 is in its slot
        guard_cnt = 0;
        while (!((((n - 1) / RD) % 8 == 3) && ((n - 1) % RD == 2)) && guard_cnt < 2 * FRAME) begin
            step();
            guard_cnt++;
        end
        check("reach_digit3", 32'(guard_cnt < 2 * FRAME), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_an", 32'(bus.an), 32'hFF);
        check("async_seg", 32'(bus.seg), 32'h7F);
        check("async_dsel", 32'(bus.digit_sel), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("async_hold_an", 32'(bus.an), 32'hFF);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) bus.displays[i] = 7'($urandom);
        run_to(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
